// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared op codes, FSM states and sizing helper for seq_arith_unit
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDSUB = 3'd1,
        MUL    = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_arith_dp.sv
// rtl/seq_arith_dp.sv - operand/accumulator registers, shift-add and restoring-divide step logic
module seq_arith_dp
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    logic [1:0]       op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    // lo_q starts as operand a: multiplier for mul (product bits shift in at the top),
    // dividend for div (quotient bits shift in at the bottom)
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   add_ab;
    logic [WIDTH:0]   sub_ab;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;

    assign add_ab    = {1'b0, lo_q} + {1'b0, mcand};
    assign sub_ab    = {1'b0, lo_q} - {1'b0, mcand};
    assign mul_sum   = lo_q[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
    assign mul_hi_n  = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    // remainder stays below the divisor, so the shifted value fits WIDTH+1 bits and
    // the top bit of the trial difference is a clean borrow
    assign div_shift = {acc, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_rem_n = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_n = {lo_q[WIDTH-2:0], div_ok};
    assign div_zero  = (mcand == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_ADD;
            mcand <= '0;
            acc   <= '0;
            lo_q  <= '0;
        end else if (load) begin
            op_q  <= op;
            mcand <= b;
            acc   <= '0;
            lo_q  <= a;
        end else if (step) begin
            if (op_q == OP_MUL) begin
                acc  <= mul_hi_n;
                lo_q <= mul_lo_n;
            end else begin
                acc  <= div_rem_n;
                lo_q <= div_quo_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (finish) begin
            div_by_zero <= 1'b0;
            case (op_q)
                OP_ADD: begin
                    result_lo <= add_ab[WIDTH-1:0];
                    result_hi <= {{(WIDTH-1){1'b0}}, add_ab[WIDTH]};
                end
                OP_SUB: begin
                    result_lo <= sub_ab[WIDTH-1:0];
                    result_hi <= {WIDTH{sub_ab[WIDTH]}};
                end
                OP_MUL: begin
                    result_lo <= mul_lo_n;
                    result_hi <= mul_hi_n;
                end
                default: begin
                    if (div_zero) begin
                        result_lo   <= '1;
                        result_hi   <= lo_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        result_lo <= div_quo_n;
                        result_hi <= div_rem_n;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - handshake FSM and iteration counter around the iterative datapath
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          finish;
    logic          div_zero;

    assign ready = (state == IDLE) || (state == DONE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                cnt <= CW'(WIDTH - 1);
            end else if (step && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load = 1'b1;
                    case (op)
                        OP_MUL:  state_n = MUL;
                        OP_DIV:  state_n = DIV;
                        default: state_n = ADDSUB;
                    endcase
                end else begin
                    state_n = IDLE;
                end
            end
            ADDSUB: begin
                finish  = 1'b1;
                state_n = DONE;
            end
            MUL: begin
                step = 1'b1;
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DIV: begin
                // a zero divisor short-circuits the iterations entirely
                if (div_zero) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    seq_arith_dp #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .finish      (finish),
        .op          (op),
        .a           (a),
        .b           (b),
        .div_zero    (div_zero),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - vector table, corner sequences and randomized model check for seq_arith_unit
module tb_seq_arith_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         lo;
        int         hi;
        int         dbz;
        int         lat;
    } vec_t;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference built from the arithmetic definition of each op
    task automatic model(input logic [1:0] o, input int x, input int y,
                         output int lo, output int hi, output int dbz, output int lat);
        int mask;
        mask = (1 << W) - 1;
        dbz  = 0;
        lat  = 1;
        case (o)
            2'b00: begin lo = (x + y) & mask; hi = (x + y) >> W; end
            2'b01: begin lo = (x - y) & mask; hi = (x < y) ? mask : 0; end
            2'b10: begin lo = (x * y) & mask; hi = (x * y) >> W; lat = W; end
            default: begin
                if (y == 0) begin lo = mask; hi = x; dbz = 1; end
                else begin lo = x / y; hi = x % y; lat = W; end
            end
        endcase
    endtask

    // Called at a negedge with ready expected high; returns at the negedge showing done
    task automatic run_op(input logic [1:0] o, input int x, input int y,
                          output int lo, output int hi, output int dbz, output int lat);
        op    = o;
        a     = W'(x);
        b     = W'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 2'($urandom);
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        lo  = int'(result_lo);
        hi  = int'(result_hi);
        dbz = int'(div_by_zero);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o, input int x, input int y,
                                 input int elo, input int ehi, input int edbz, input int elat);
        int lo, hi, dbz, lat;
        run_op(o, x, y, lo, hi, dbz, lat);
        check({tag, ".lo"}, lo, elo);
        check({tag, ".hi"}, hi, ehi);
        check({tag, ".dbz"}, dbz, edbz);
        check({tag, ".lat"}, lat, elat);
    endtask

    initial begin
        vec_t vecs[8];
        int lo, hi, dbz, lat;
        int done_cnt, done_at;

        vecs[0] = '{2'b00, 200, 100,  44,   1, 0, 1};
        vecs[1] = '{2'b01,   5,   7, 254, 255, 0, 1};
        vecs[2] = '{2'b10, 255, 255,   1, 254, 0, 8};
        vecs[3] = '{2'b10,   0,  37,   0,   0, 0, 8};
        vecs[4] = '{2'b11, 200,   7,  28,   4, 0, 8};
        vecs[5] = '{2'b11,   3,   9,   0,   3, 0, 8};
        vecs[6] = '{2'b11,   9,   0, 255,   9, 1, 1};
        vecs[7] = '{2'b00,   1,   1,   2,   0, 0, 1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset.ready", int'(ready), 1);
        check("reset.done", int'(done), 0);
        check("reset.lo", int'(result_lo), 0);
        check("reset.hi", int'(result_hi), 0);
        check("reset.dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors issued back-to-back, each start landing in the previous DONE cycle
        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].lo, vecs[i].hi, vecs[i].dbz, vecs[i].lat);
        end
        @(negedge clk);
        check("done_single_cycle", int'(done), 0);
        check("idle_ready", int'(ready), 1);

        // start hammered during a multiply with changing operands
        op    = 2'b10;
        a     = 8'd12;
        b     = 8'd13;
        start = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k - 1;
                    lo = int'(result_lo);
                    hi = int'(result_hi);
                end
            end
            start = (k <= 8);
            a     = W'($urandom);
            b     = W'($urandom);
            op    = 2'($urandom);
        end
        start = 1'b0;
        check("busy_start.done_pulses", done_cnt, 1);
        check("busy_start.lat", done_at, 8);
        check("busy_start.lo", lo, 156);
        check("busy_start.hi", hi, 0);

        // Reset in the middle of a multiply
        op    = 2'b10;
        a     = 8'd200;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.ready", int'(ready), 1);
        check("midreset.done", int'(done), 0);
        check("midreset.lo", int'(result_lo), 0);
        check("midreset.hi", int'(result_hi), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midreset.no_done", done_cnt, 0);
        run_and_check("post_reset_add", 2'b00, 10, 20, 30, 0, 0, 1);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] ro;
            int rx, ry, elo, ehi, edbz, elat;
            ro = 2'($urandom);
            rx = int'($urandom_range(0, 255));
            ry = (($urandom % 8) == 0) ? 0 : int'($urandom_range(0, 255));
            model(ro, rx, ry, elo, ehi, edbz, elat);
            run_and_check($sformatf("rand%0d_op%0d_%0d_%0d", i, ro, rx, ry),
                          ro, rx, ry, elo, ehi, edbz, elat);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised iterative arithmetic unit for the calculator datapath; successor to the fixed 8-bit add/sub/repeated-add/repeated-subtract controller.
- Executes one of four ops (add, sub, multiply, divide) on WIDTH-bit unsigned operands under a start/ready/done handshake.
- Multiply is shift-add and divide is restoring. Both have a fixed latency of WIDTH cycles, independent of operand values.
- Sits between the operand registers/ROM reader and the result writer; the upstream sequencer issues one op per handshake.

Parameters:
- WIDTH, 8, operand width in bits (>=2); the 2*WIDTH-bit result is split into result_hi and result_lo.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  2  operation code: 00 add, 01 sub, 10 mul, 11 div.
- a  in  WIDTH  operand A (dividend for div).
- b  in  WIDTH  operand B (divisor for div).
- ready  out  1  unit can accept start this cycle.
- done  out  1  one-cycle pulse; results valid and updated.
- result_lo  out  WIDTH  sum/difference low bits, product low half, or quotient.
- result_hi  out  WIDTH  carry/borrow extension, product high half, or remainder.
- div_by_zero  out  1  last completed op was a divide with b=0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, done=0, result_lo=0, result_hi=0, div_by_zero=0, iteration counter=0. Applies immediately, including mid-operation; the in-flight op is discarded with no done pulse.
- Acceptance: at a posedge with start=1 and ready=1 (edge E0), the unit latches op, a and b. ready drops after E0. Changes on a/b/op while busy have no effect. start while ready=0 is ignored and not queued.
- States:
  - IDLE: ready=1.
  - ADDSUB: one cycle.
  - MUL: WIDTH cycles.
  - DIV: WIDTH cycles, or a one-cycle zero-divisor path.
  - Op state then goes to DONE, which lasts one cycle, then back to IDLE.
- Latency L: add, sub and div-by-zero L=1; mul and div (b!=0) L=WIDTH.
  - Results and div_by_zero are registered at edge E0+L; the state becomes DONE at that edge.
  - done=1 and ready=1 for exactly the cycle after E0+L.
  - A start in the DONE cycle is accepted (back-to-back ops); done still deasserts next cycle unless the new op also completes.
- Add: result_lo = (a+b) mod 2^WIDTH; result_hi = {0…0, carry_out}.
- Sub: result_lo = (a-b) mod 2^WIDTH; result_hi = all ones if a<b, else 0. {hi,lo} is the 2*WIDTH-bit two's-complement difference.
- Mul: {result_hi,result_lo} = a*b, exact and never overflowing.
  - Each iteration examines one multiplier bit LSB first: conditional add of the multiplicand into the upper accumulator, then right shift.
  - a=0 or b=0 still takes WIDTH cycles.
- Div (b!=0): result_lo = a / b, result_hi = a % b.
  - Each iteration shifts the remainder in one dividend bit MSB first, trial-subtracts b, and restores on a negative result.
  - a<b gives quotient 0 and remainder a.
- Div (b=0): result_lo = all ones, result_hi = a, div_by_zero=1, L=1.
- div_by_zero clears to 0 on completion of any other op. Results hold their value until the next completion.
- Iteration counter width: $clog2(WIDTH)+1. It counts WIDTH-1 down to 0, and the op state exits when it reaches 0.

Decomposition:
- Shared package seq_arith_pkg holds:
  - op codes OP_ADD, OP_SUB, OP_MUL, OP_DIV (2-bit);
  - state enum IDLE, ADDSUB, MUL, DIV, DONE;
  - a function for the counter width.
- One sub-module, seq_arith_dp: the datapath holding the accumulator/remainder and shift registers with the per-iteration step logic, driven by load/step/op controls from the FSM in seq_arith_unit.

Test Plan:
- WIDTH=8, add 200+100 -> done 2 cycles after E0 (L=1); lo=44, hi=1. Then sub 5-7 issued in the DONE cycle -> lo=254, hi=255.
- mul 255*255 -> done exactly in the cycle after E0+8; hi=254, lo=1 (0xFE01). Also mul 0*37 -> hi=0, lo=0, same latency.
- div 200/7 -> lo=28, hi=4, div_by_zero=0, L=8. Also div 3/9 -> lo=0, hi=3.
- div 9/0 -> L=1; lo=255, hi=9, div_by_zero=1. A following add 1+1 -> lo=2, hi=0, div_by_zero=0.
- start pulsed every cycle during a mul with changing a/b -> only the first op executes, with one done pulse and the result from the latched operands.
- rst_n low for 1 cycle at iteration 3 of a mul -> immediately ready=1, done=0, results=0; no done pulse follows. A later add 10+20 gives lo=30.
